// File: rtl/apb_master_if.sv
// Command/response port and APB3 request/completion signals of apb_master.
// The master modport is the requester's view; slave is the view of whatever drives commands and completes transfers.
interface apb_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );
endinterface

// File: rtl/apb_master.sv
// APB3 requester: single-beat command in, SETUP/ACCESS transfer out, one-cycle response pulse back.
// Optional ACCESS wait-state abort is built only when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         pclk,
    input  logic         presetn,
    apb_master_if.master bus
);
    // state  | meaning
    // IDLE   | no transfer; cmd_ready high
    // SETUP  | psel high, penable low, request registered
    // ACCESS | psel and penable high, waiting for pready
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_done;
    logic        w_abort;
    logic        w_timeout;

    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic [3:0]  r_pstrb;
    logic [2:0]  r_pprot;
    logic        r_pwrite;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be >= 1");
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                // a completer answering on the timeout edge still wins
                if (bus.pready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_paddr  <= 32'h0;
            r_pwdata <= 32'h0;
            r_pstrb  <= 4'h0;
            r_pprot  <= 3'h0;
            r_pwrite <= 1'b0;
        end else if (w_accept) begin
            r_paddr  <= bus.cmd_addr;
            r_pwdata <= bus.cmd_wdata;
            r_pstrb  <= bus.cmd_write ? bus.cmd_strb : 4'h0;
            r_pprot  <= bus.cmd_prot;
            r_pwrite <= bus.cmd_write;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_done | w_abort;
            if (w_done) begin
                r_rsp_rdata <= r_pwrite ? 32'h0 : bus.prdata;
                r_rsp_err   <= bus.pslverr;
            end else if (w_abort) begin
                r_rsp_rdata <= 32'h0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_to_cnt;

    // counts completed wait states; the abort fires on the TIMEOUT_CYCLES-th one
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_ACCESS && !bus.pready) begin
            r_to_cnt <= r_to_cnt + CW'(1);
        end
    end

    assign w_timeout = (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.psel      = (r_state != ST_IDLE);
    assign bus.penable   = (r_state == ST_ACCESS);
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.pstrb     = r_pstrb;
    assign bus.pprot     = r_pprot;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
endmodule

// File: doc/apb_master.md
# apb_master

APB3 requester that turns a single-beat command/response interface into compliant SETUP/ACCESS transfers toward the 4-register APB slave and any other completer on the bus. It sits directly upstream of the slave on the `pclk` domain. It holds all APB request signals stable for the whole transfer, tolerates unbounded wait states, and returns read data and `pslverr` as a one-cycle response pulse.

## Interface
- `TIMEOUT_CYCLES`, 16, number of ACCESS cycles with `pready` low before abort. Must be ≥1. Used only with `APB_MASTER_TIMEOUT_EN`.
- `pclk` in 1: bus clock; all logic is on its rising edge.
- `presetn` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_write` in 1: 1 for write, 0 for read.
- `cmd_addr` in 32: target address.
- `cmd_wdata` in 32: write data.
- `cmd_strb` in 4: byte strobes for writes.
- `cmd_prot` in 3: protection attributes.
- `rsp_valid` out 1: one-cycle completion pulse. No backpressure.
- `rsp_rdata` out 32: read data. 0 for writes and aborts.
- `rsp_err` out 1: `pslverr` or timeout. Valid with `rsp_valid`.
- `psel`, `penable`, `pwrite` out 1: APB controls.
- `paddr` out 32, `pwdata` out 32, `pstrb` out 4, `pprot` out 3: APB request.
- `prdata` in 32, `pready` in 1, `pslverr` in 1: APB completion.

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state is IDLE.
- `cmd_ready` = (state == IDLE), combinational.
- IDLE → SETUP on accept:
  - Register `paddr`, `pwrite`, `pwdata`, `pprot`.
  - Register `pstrb` = `cmd_strb` for writes, 4'b0000 for reads.
  - Set `psel`=1, `penable`=0.
- SETUP → ACCESS unconditionally; set `penable`=1.
- ACCESS with `pready`=0: stay in ACCESS. All request outputs are unchanged.
- ACCESS with `pready`=1 → IDLE:
  - Set `psel`=`penable`=0.
  - Pulse `rsp_valid`=1 for exactly one cycle.
  - `rsp_err` = `pslverr`.
  - `rsp_rdata` = `prdata` if read, else 0.
- After completion, `paddr`/`pwdata`/`pstrb`/`pprot`/`pwrite` hold their last values until the next accept.
- `rsp_rdata`/`rsp_err` hold until the next completion.
- `pslverr` and `prdata` are sampled only on the completing edge. They are ignored otherwise.
- A new command may be accepted in the cycle `rsp_valid` is high, since the FSM is already IDLE.

## Timing
- Reset values: `psel`, `penable`, `pwrite`, `rsp_valid`, `rsp_err` = 0. `paddr`, `pwdata`, `rsp_rdata` = 32'h0. `pstrb` = 4'h0. `pprot` = 3'h0. `cmd_ready` = 1.
- Accept edge E0 → SETUP cycle → ACCESS from E1.
- Completion edge is the first ACCESS edge Ek (k ≥ 2) sampling `pready`=1. `rsp_valid` is high in the cycle after Ek.
- Zero-wait completer: 3 cycles from accept to `rsp_valid`. Each wait state adds 1 cycle.
- Registered-`pready` slave (asserts one edge after `psel&&penable`): 4 cycles from accept to `rsp_valid`.
- Throughput limit: one transfer per 3 cycles minimum, with no back-to-back ACCESS → SETUP.
- Reset asserted mid-transfer:
  - All outputs go to reset values immediately (asynchronously).
  - No `rsp_valid` is issued for the aborted command.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entering ACCESS and increments each ACCESS cycle with `pready`=0.
  - When the count reaches `TIMEOUT_CYCLES` with `pready` still 0, the transfer aborts to IDLE: `psel`=`penable`=0, `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0.
  - If `pready`=1 on that same edge, normal completion wins.
- `APB_MASTER_TIMEOUT_EN` undefined: no counter is built, ACCESS waits indefinitely, and `TIMEOUT_CYCLES` is ignored.

## Test plan
- Write 0xDEADBEEF to 0x8, strb 4'hF, zero-wait completer → `psel` high 2 cycles, `penable` high 1 cycle, `paddr`=0x8 stable; then `rsp_valid` 1 cycle, `rsp_err`=0, `rsp_rdata`=0.
- Read 0x8 from the register-file slave after the write above → `pstrb`=0; `rsp_rdata`=0xDEADBEEF 4 cycles after accept.
- Read with 3 wait states, `prdata` toggling during waits, 0x1234 on the `pready` edge → `rsp_rdata`=0x1234; request signals unchanged across all wait cycles.
- Access to an out-of-range address (slave raises `pslverr`) → `rsp_err`=1; next command accepted in the same cycle as `rsp_valid`.
- `presetn` low during ACCESS → `psel`/`penable` drop without waiting for a clock edge; no `rsp_valid`; `cmd_ready`=1 after release.
- `APB_MASTER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `pready` held 0 → abort after 4 ACCESS cycles with `rsp_err`=1 and `rsp_rdata`=0. Repeat with `pready`=1 on the 4th cycle → normal completion.
